// File: rtl/tinyalu_array_pkg.sv
// Shared types and register map constants for the tinyalu_array channel array.
package tinyalu_array_pkg;

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpAdd = 3'b001,
    OpAnd = 3'b010,
    OpXor = 3'b011,
    OpMul = 3'b100
  } op_e;

  typedef enum logic [0:0] {
    StIdle,
    StMulBusy
  } ch_state_e;

  // Per-channel register offsets within a channel's 4-word window.
  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] OPCNT  = 2'd1;
  localparam logic [1:0] ERRCNT = 2'd2;
  localparam logic [1:0] STATUS = 2'd3;

  localparam logic [15:0] CH_BASE   = 16'h0100;
  localparam int unsigned CH_STRIDE = 4;
  localparam logic [15:0] ID_ADDR   = 16'h0000;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tinyalu_array_if.sv
// Register bus shared by all ALU channels: one strobe, read/write select, address and data.
interface tinyalu_array_if;
  logic        bus_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;

  modport master (
    output bus_valid, bus_op, bus_addr, bus_wr_data,
    input  bus_rd_data
  );

  modport slave (
    input  bus_valid, bus_op, bus_addr, bus_wr_data,
    output bus_rd_data
  );
endinterface

// File: rtl/tinyalu_array_ch.sv
// One ALU channel: start/done handshake, multi-cycle multiply FSM, CTRL/STATUS bits and
// saturating completion and error counters.
module tinyalu_ch
  import tinyalu_array_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  input  logic                ctrl_we,
  input  logic [1:0]          ctrl_wdata,
  input  logic                sticky_clr,
  output logic                en,
  output logic                irq_mask,
  output logic                busy,
  output logic                done_sticky,
  output logic [15:0]         opcnt,
  output logic [15:0]         errcnt
);

  localparam int unsigned CntW = $clog2(MUL_LAT);

  ch_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] res_q, res_d, prod;
  logic                done_q, done_d;
  logic                err;
  logic [15:0]         opcnt_q, errcnt_q;
  logic                en_q, mask_q, sticky_q;

  assign prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && en_q) begin
          case (op_e'(op))
            OpAdd: begin
              res_d           = '0;
              res_d[DATA_W:0] = {1'b0, a} + {1'b0, b};
              done_d          = 1'b1;
            end
            OpAnd: begin
              res_d  = {{DATA_W{1'b0}}, a & b};
              done_d = 1'b1;
            end
            OpXor: begin
              res_d  = {{DATA_W{1'b0}}, a ^ b};
              done_d = 1'b1;
            end
            OpMul: begin
              a_d     = a;
              b_d     = b;
              cnt_d   = CntW'(MUL_LAT - 1);
              state_d = StMulBusy;
            end
            OpNop: ;
            default: err = 1'b1;
          endcase
        end
      end
      StMulBusy: begin
        // Done lands MUL_LAT cycles after the start cycle, when the count reaches zero.
        cnt_d = cnt_q - CntW'(1);
        if (start && en_q) err = 1'b1;
        if (cnt_d == '0) begin
          res_d   = prod;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      opcnt_q  <= '0;
      errcnt_q <= '0;
      en_q     <= 1'b1;
      mask_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
      if (done_d) opcnt_q <= sat_inc(opcnt_q);
      if (err) errcnt_q <= sat_inc(errcnt_q);
      if (ctrl_we) {mask_q, en_q} <= ctrl_wdata;
      // A completion in the same cycle as a clear keeps the sticky bit set.
      if (done_d) sticky_q <= 1'b1;
      else if (sticky_clr) sticky_q <= 1'b0;
    end
  end

  assign done        = done_q;
  assign result      = res_q;
  assign en          = en_q;
  assign irq_mask    = mask_q;
  assign busy        = (state_q == StMulBusy);
  assign done_sticky = sticky_q;
  assign opcnt       = opcnt_q;
  assign errcnt      = errcnt_q;

endmodule

// File: rtl/tinyalu_array.sv
// NUM_CH independent ALU channels behind one register bus (decode and read mux live here).
// Define TINYALU_ARRAY_IRQ_EN to add the registered irq output.
module tinyalu_array
  import tinyalu_array_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   A,
  input  logic [NUM_CH*DATA_W-1:0]   B,
  input  logic [NUM_CH*3-1:0]        op,
  input  logic [NUM_CH-1:0]          start,
  output logic [NUM_CH-1:0]          done,
  output logic [NUM_CH*2*DATA_W-1:0] result,
`ifdef TINYALU_ARRAY_IRQ_EN
  output logic                       irq,
`endif
  tinyalu_array_if.slave             bus
);

  localparam logic [15:0] ChEnd = 16'(CH_BASE + NUM_CH * CH_STRIDE);

  logic        wr, rd, ch_hit;
  logic [5:0]  off;
  logic [3:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [15:0] rd_d, rd_q;
  logic        unused_wdata;

  logic [NUM_CH-1:0] ctrl_we, sticky_clr, en, irq_mask, busy, sticky;
  logic [15:0]       opcnt  [NUM_CH];
  logic [15:0]       errcnt [NUM_CH];

  assign wr      = bus.bus_valid && bus.bus_op;
  assign rd      = bus.bus_valid && !bus.bus_op;
  assign ch_hit  = (bus.bus_addr >= CH_BASE) && (bus.bus_addr < ChEnd);
  assign off     = bus.bus_addr[5:0] - CH_BASE[5:0];
  assign ch_sel  = off[5:2];
  assign reg_sel = off[1:0];
  assign unused_wdata = ^bus.bus_wr_data[15:2];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ctrl_we[c]    = wr && ch_hit && (ch_sel == 4'(c)) && (reg_sel == CTRL);
    assign sticky_clr[c] = wr && ch_hit && (ch_sel == 4'(c)) && (reg_sel == STATUS)
                           && bus.bus_wr_data[1];

    tinyalu_ch #(
      .DATA_W  (DATA_W),
      .MUL_LAT (MUL_LAT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .a           (A[c*DATA_W +: DATA_W]),
      .b           (B[c*DATA_W +: DATA_W]),
      .op          (op[c*3 +: 3]),
      .start       (start[c]),
      .done        (done[c]),
      .result      (result[c*2*DATA_W +: 2*DATA_W]),
      .ctrl_we     (ctrl_we[c]),
      .ctrl_wdata  (bus.bus_wr_data[1:0]),
      .sticky_clr  (sticky_clr[c]),
      .en          (en[c]),
      .irq_mask    (irq_mask[c]),
      .busy        (busy[c]),
      .done_sticky (sticky[c]),
      .opcnt       (opcnt[c]),
      .errcnt      (errcnt[c])
    );
  end

  always_comb begin
    rd_d = '0;
    if (bus.bus_addr == ID_ADDR) begin
      rd_d = {8'(NUM_CH), 8'(DATA_W)};
    end else if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 4'(c)) begin
          unique case (reg_sel)
            CTRL:    rd_d = {14'b0, irq_mask[c], en[c]};
            OPCNT:   rd_d = opcnt[c];
            ERRCNT:  rd_d = errcnt[c];
            STATUS:  rd_d = {14'b0, sticky[c], busy[c]};
            default: rd_d = '0;
          endcase
        end
      end
    end
  end

  // Read data is captured at the access edge, so a coincident counter bump is not visible.
  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else if (rd) rd_q <= rd_d;
  end

  assign bus.bus_rd_data = rd_q;

`ifdef TINYALU_ARRAY_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= |(sticky & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_tinyalu_array.sv
// Self-checking bench for tinyalu_array: per-feature tasks with a per-channel result scoreboard.
module tb_tinyalu_array;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [5:0]  op;
  logic [1:0]  start, done;
  logic [31:0] result;
`ifdef TINYALU_ARRAY_IRQ_EN
  logic        irq;
`endif

  tinyalu_array_if bus ();

  tinyalu_array #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .done   (done),
    .result (result),
`ifdef TINYALU_ARRAY_IRQ_EN
    .irq    (irq),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int opc [2];
  int errc [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int done_seen [2];

  initial begin
    done_seen[0] = 0;
    done_seen[1] = 0;
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) if (done[c] === 1'b1) done_seen[c] = done_seen[c] + 1;
  end

  function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    case (o)
      3'b001:  return {7'b0, ({1'b0, a} + {1'b0, b})};
      3'b010:  return {8'b0, a & b};
      3'b011:  return {8'b0, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] pop_exp(input int c);
    if (c == 0) return (exp_q0.size() > 0) ? exp_q0.pop_front() : 16'hxxxx;
    return (exp_q1.size() > 0) ? exp_q1.pop_front() : 16'hxxxx;
  endfunction

  // All tasks are entered on a falling edge and return on one.
  task automatic issue(input int c, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input bit expect_done);
    A[c*8 +: 8]  = a;
    B[c*8 +: 8]  = b;
    op[c*3 +: 3] = o;
    start[c]     = 1'b1;
    if (expect_done) begin
      if (c == 0) exp_q0.push_back(model(o, a, b));
      else exp_q1.push_back(model(o, a, b));
      opc[c]++;
    end
  endtask

  task automatic wait_done(input int c, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = '0;
      if (done[c] === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus.bus_valid   = 1'b1;
    bus.bus_op      = 1'b1;
    bus.bus_addr    = addr;
    bus.bus_wr_data = data;
    @(negedge clk);
    bus.bus_valid = 1'b0;
    bus.bus_op    = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    bus.bus_valid = 1'b1;
    bus.bus_op    = 1'b0;
    bus.bus_addr  = addr;
    @(negedge clk);
    data = bus.bus_rd_data;
    bus.bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    n_cmp++;
    if (done !== 2'b00) begin
      n_fail++; $display("FAIL reset_done: got %b want 00", done);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 00000000", result);
    end
    n_cmp++;
    if (bus.bus_rd_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 0000", bus.bus_rd_data);
    end
    bus_read(16'h0100, rd);
    n_cmp++;
    if (rd !== 16'h0001) begin
      n_fail++; $display("FAIL reset_ctrl0: got %h want 0001", rd);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [15:0] rd;
    logic [15:0] e;
    issue(0, 3'b001, 8'hFF, 8'h01, 1'b1);
    wait_done(0, 5, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL add_latency: got %0d want 1", lat);
    end
    e = pop_exp(0);
    n_cmp++;
    if (result[15:0] !== e) begin
      n_fail++; $display("FAIL add_result: got %h want %h", result[15:0], e);
    end
    @(negedge clk);
    n_cmp++;
    if (done[0] !== 1'b0) begin
      n_fail++; $display("FAIL add_done_one_cycle: got %b want 0", done[0]);
    end
    bus_read(16'h0101, rd);
    n_cmp++;
    if (rd !== 16'(opc[0])) begin
      n_fail++; $display("FAIL add_opcnt0: got %h want %h", rd, 16'(opc[0]));
    end
    bus_read(16'h0103, rd);
    n_cmp++;
    if (rd !== 16'h0002) begin
      n_fail++; $display("FAIL add_sticky_set: got %h want 0002", rd);
    end
    bus_write(16'h0103, 16'h0002);
    bus_read(16'h0103, rd);
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++; $display("FAIL add_sticky_w1c: got %h want 0000", rd);
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [15:0] rd;
    logic [15:0] e;
    issue(1, 3'b100, 8'h0C, 8'h0B, 1'b1);
    @(negedge clk);
    // Second start while busy, with different operands, plus a STATUS read.
    A[15:8]  = 8'h77;
    op[5:3]  = 3'b001;
    start[1] = 1'b1;
    errc[1]++;
    bus_read(16'h0107, rd);
    start = '0;
    n_cmp++;
    if (rd !== 16'h0001) begin
      n_fail++; $display("FAIL mul_busy_status: got %h want 0001", rd);
    end
    wait_done(1, 6, lat);
    n_cmp++;
    if (2 + lat !== MUL_LAT) begin
      n_fail++; $display("FAIL mul_latency: got %0d want %0d", 2 + lat, MUL_LAT);
    end
    e = pop_exp(1);
    n_cmp++;
    if (result[31:16] !== e) begin
      n_fail++; $display("FAIL mul_result: got %h want %h", result[31:16], e);
    end
    bus_read(16'h0106, rd);
    n_cmp++;
    if (rd !== 16'(errc[1])) begin
      n_fail++; $display("FAIL mul_errcnt1: got %h want %h", rd, 16'(errc[1]));
    end
    bus_read(16'h0105, rd);
    n_cmp++;
    if (rd !== 16'(opc[1])) begin
      n_fail++; $display("FAIL mul_opcnt1: got %h want %h", rd, 16'(opc[1]));
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [15:0] e;
    issue(0, 3'b011, 8'hF0, 8'h3C, 1'b1);
    issue(1, 3'b010, 8'hF0, 8'h3C, 1'b1);
    wait_done(0, 4, lat);
    n_cmp++;
    if (lat !== 1 || done[1] !== 1'b1) begin
      n_fail++; $display("FAIL simul_done: got lat=%0d done=%b want lat=1 done=11", lat, done);
    end
    e = pop_exp(0);
    n_cmp++;
    if (result[15:0] !== e) begin
      n_fail++; $display("FAIL simul_xor: got %h want %h", result[15:0], e);
    end
    e = pop_exp(1);
    n_cmp++;
    if (result[31:16] !== e) begin
      n_fail++; $display("FAIL simul_and: got %h want %h", result[31:16], e);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] e;
    issue(0, 3'b100, 8'h05, 8'h07, 1'b1);
    wait_done(0, 6, lat);
    // Next multiply starts on the done cycle.
    issue(0, 3'b100, 8'hFF, 8'hFF, 1'b1);
    n_cmp++;
    if (lat !== MUL_LAT) begin
      n_fail++; $display("FAIL b2b_lat1: got %0d want %0d", lat, MUL_LAT);
    end
    e = pop_exp(0);
    n_cmp++;
    if (result[15:0] !== e) begin
      n_fail++; $display("FAIL b2b_res1: got %h want %h", result[15:0], e);
    end
    wait_done(0, 6, lat);
    n_cmp++;
    if (lat !== MUL_LAT) begin
      n_fail++; $display("FAIL b2b_lat2: got %0d want %0d", lat, MUL_LAT);
    end
    e = pop_exp(0);
    n_cmp++;
    if (result[15:0] !== e) begin
      n_fail++; $display("FAIL b2b_res2: got %h want %h", result[15:0], e);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (result[15:0] !== 16'hFE01) begin
      n_fail++; $display("FAIL b2b_hold: got %h want FE01", result[15:0]);
    end
  endtask

  task automatic test_illegal();
    int snap;
    logic [15:0] rd;
    snap = done_seen[0];
    issue(0, 3'b101, 8'h01, 8'h02, 1'b0);
    errc[0]++;
    @(negedge clk);
    start = '0;
    issue(0, 3'b000, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    start = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_seen[0] - snap !== 0) begin
      n_fail++; $display("FAIL illegal_no_done: got %0d pulses want 0", done_seen[0] - snap);
    end
    bus_read(16'h0102, rd);
    n_cmp++;
    if (rd !== 16'(errc[0])) begin
      n_fail++; $display("FAIL illegal_errcnt0: got %h want %h", rd, 16'(errc[0]));
    end
    bus_read(16'h0101, rd);
    n_cmp++;
    if (rd !== 16'(opc[0])) begin
      n_fail++; $display("FAIL illegal_opcnt0: got %h want %h", rd, 16'(opc[0]));
    end
  endtask

  task automatic test_disable();
    int snap;
    int lat;
    logic [15:0] rd;
    logic [15:0] e;
    bus_write(16'h0100, 16'h0000);
    bus_read(16'h0100, rd);
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++; $display("FAIL dis_ctrl: got %h want 0000", rd);
    end
    snap = done_seen[0];
    issue(0, 3'b001, 8'h11, 8'h22, 1'b0);
    @(negedge clk);
    start = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_seen[0] - snap !== 0) begin
      n_fail++; $display("FAIL dis_no_done: got %0d pulses want 0", done_seen[0] - snap);
    end
    bus_read(16'h0101, rd);
    n_cmp++;
    if (rd !== 16'(opc[0])) begin
      n_fail++; $display("FAIL dis_opcnt0: got %h want %h", rd, 16'(opc[0]));
    end
    bus_read(16'h0102, rd);
    n_cmp++;
    if (rd !== 16'(errc[0])) begin
      n_fail++; $display("FAIL dis_errcnt0: got %h want %h", rd, 16'(errc[0]));
    end
    bus_write(16'h0100, 16'h0001);
    issue(0, 3'b001, 8'h12, 8'h34, 1'b1);
    wait_done(0, 4, lat);
    e = pop_exp(0);
    n_cmp++;
    if (lat !== 1 || result[15:0] !== e) begin
      n_fail++; $display("FAIL reen_add: got lat=%0d res=%h want lat=1 res=%h", lat,
                         result[15:0], e);
    end
  endtask

  task automatic test_bus_map();
    logic [15:0] rd;
    bus_write(16'h0101, 16'h1234);
    bus_write(16'h0000, 16'hFFFF);
    bus_read(16'h0101, rd);
    n_cmp++;
    if (rd !== 16'(opc[0])) begin
      n_fail++; $display("FAIL ro_opcnt_write: got %h want %h", rd, 16'(opc[0]));
    end
    bus_read(16'h0000, rd);
    n_cmp++;
    if (rd !== 16'h0208) begin
      n_fail++; $display("FAIL id: got %h want 0208", rd);
    end
    bus_read(16'h0108, rd);
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++; $display("FAIL unmapped_ch2: got %h want 0000", rd);
    end
    bus_read(16'h8000, rd);
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++; $display("FAIL unmapped_high: got %h want 0000", rd);
    end
    // Read data holds while no read is issued.
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.bus_rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL rd_hold: got %h want 0000", bus.bus_rd_data);
    end
  endtask

`ifdef TINYALU_ARRAY_IRQ_EN
  task automatic test_irq();
    int lat;
    logic [15:0] e;
    bus_write(16'h0100, 16'h0003);
    issue(0, 3'b001, 8'h01, 8'h01, 1'b1);
    wait_done(0, 4, lat);
    e = pop_exp(0);
    n_cmp++;
    if (result[15:0] !== e) begin
      n_fail++; $display("FAIL irq_add_result: got %h want %h", result[15:0], e);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_set: got %b want 1", irq);
    end
    bus_write(16'h0103, 16'h0002);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_hold_at_w1c: got %b want 1", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %b want 0", irq);
    end
  endtask
`endif

  task automatic test_reset_mid_mul();
    int snap;
    logic [15:0] rd;
    logic [15:0] want;
    snap = done_seen[1];
    issue(1, 3'b100, 8'h03, 8'h04, 1'b0);
    @(negedge clk);
    start = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    opc  = '{0, 0};
    errc = '{0, 0};
    exp_q0.delete();
    exp_q1.delete();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_seen[1] - snap !== 0) begin
      n_fail++; $display("FAIL rst_mul_no_done: got %0d pulses want 0", done_seen[1] - snap);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL rst_mul_result: got %h want 00000000", result);
    end
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        want = (r == 0) ? 16'h0001 : 16'h0000;
        bus_read(16'(16'h0100 + 4 * c + r), rd);
        n_cmp++;
        if (rd !== want) begin
          n_fail++; $display("FAIL rst_reg_ch%0d_off%0d: got %h want %h", c, r, rd, want);
        end
      end
    end
    bus_read(16'h0000, rd);
    n_cmp++;
    if (rd !== 16'h0208) begin
      n_fail++; $display("FAIL rst_id: got %h want 0208", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    A = '0;
    B = '0;
    op = '0;
    start = '0;
    reset = 1'b1;
    opc  = '{0, 0};
    errc = '{0, 0};
    bus.bus_valid   = 1'b0;
    bus.bus_op      = 1'b0;
    bus.bus_addr    = '0;
    bus.bus_wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_simultaneous();
    test_back_to_back();
    test_illegal();
    test_disable();
    test_bus_map();
`ifdef TINYALU_ARRAY_IRQ_EN
    test_irq();
`endif
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
